cla_addsub_pipe: RTL and testbench
==================================

CLA_ADDSUB_PIPE -- requirements
Module: cla_addsub_pipe

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; SHALL be a multiple of 4 and at least 8.
REQ-002 Parameter: STAGES, default 2, pipeline depth; SHALL be in the range 1..WIDTH/4 and SHALL divide WIDTH/4 evenly.
REQ-003 Ports (name, direction, width, meaning) SHALL be as follows; one clock, reset synchronous and active-high:
  clk        in   1      rising-edge clock
  rst        in   1      synchronous, active-high reset
  in_valid   in   1      operand beat present
  in_ready   out  1      block accepts beat
  a          in   WIDTH  operand A
  b          in   WIDTH  operand B
  carry_in   in   1      carry into bit 0
  add_sub    in   1      0 = add, 1 = invert b
  sat        in   1      1 = signed saturation on overflow
  out_valid  out  1      result beat present
  out_ready  in   1      consumer accepts result
  sum_dif    out  WIDTH  result
  C          out  1      carry out of MSB
  V          out  1      signed overflow
  N          out  1      sum_dif[WIDTH-1]
  Z          out  1      sum_dif == 0

Function
REQ-004 Raw result SHALL be a + (b XOR {WIDTH{add_sub}}) + carry_in, truncated to WIDTH bits. The block SHALL NOT add an implicit +1 on subtract; the caller drives carry_in=1 for two's-complement subtract.
REQ-005 C SHALL be the carry out of bit WIDTH-1 of the raw sum.
REQ-006 V SHALL be the XOR of the carry into bit WIDTH-1 and the carry out of bit WIDTH-1.
REQ-007 When sat=1 and V=1, sum_dif SHALL be 0 followed by all 1s if a[WIDTH-1]=0, and 1 followed by all 0s otherwise. C and V SHALL report raw values. N and Z SHALL reflect the saturated sum_dif.
REQ-008 Carry generation SHALL be two-level lookahead: 4-bit groups produce group P/G, and groups combine via lookahead within each stage.
REQ-009 The WIDTH/4 groups SHALL be split into STAGES equal segments, least-significant segment first. Stage k SHALL compute segment k using the registered carry out of stage k-1. Unprocessed operand bits and completed sum bits SHALL travel with the beat.
REQ-010 Latency SHALL be exactly STAGES cycles from an accepted input beat (in_valid & in_ready at edge) to out_valid=1 for that beat. Throughput SHALL be one beat per cycle when out_ready=1.
REQ-011 in_ready SHALL equal !out_valid | out_ready (global stall). While stalled, all stage registers SHALL hold.
REQ-012 Once asserted, out_valid, sum_dif and the flags SHALL stay stable until out_ready=1.
REQ-013 Beats SHALL leave in acceptance order, with none dropped or duplicated.
REQ-014 Pipeline bubbles (in_valid=0 on an accept slot) SHALL propagate as invalid stages and SHALL NOT produce out_valid.
REQ-015 Simultaneous accept and emit in the same cycle SHALL be legal and SHALL advance all stages by one.

Reset
REQ-016 With rst=1 at a clock edge, all stage valid bits, out_valid, sum_dif, C, V, N and Z SHALL be 0 on the following cycle.
REQ-017 in_ready SHALL be 1 during and after reset, per REQ-011.
REQ-018 Reset mid-operation SHALL discard all in-flight beats without emitting them.
REQ-019 Data registers other than outputs need not be reset.

Structure
REQ-020 Shared package cla_pkg SHALL hold: constant GROUP_W=4; typedef flags_t struct {C,V,N,Z}; and a function that builds the saturation value for a given width.
REQ-021 Sub-module cla_group4 SHALL implement one combinational 4-bit group: inputs a[3:0], b[3:0], add_sub, cin; outputs sum[3:0], P, G.
REQ-022 cla_addsub_pipe SHALL instantiate WIDTH/4 cla_group4 instances via generate, and SHALL contain no behavioural '+' on full-width operands.

Verification (WIDTH=32, STAGES=2 unless noted)
REQ-023 a=0x7FFFFFFF, b=1, add_sub=0, carry_in=0, sat=0 -> 2 cycles later sum_dif=0x80000000, V=1, C=0, N=1, Z=0.
REQ-024 Same operands with sat=1 -> sum_dif=0x7FFFFFFF, V=1, N=0.
REQ-025 a=5, b=5, add_sub=1, carry_in=1 -> sum_dif=0, Z=1, C=1, V=0. Also a=0xFFFFFFFF, b=1, add -> sum_dif=0, C=1, V=0, Z=1.
REQ-026 Four back-to-back beats with out_ready=0 for cycles 1-4:
  - in_ready SHALL drop once out_valid=1.
  - After out_ready rises, all four results SHALL emerge in order with no loss.
  - Held outputs SHALL be unchanged while stalled.
REQ-027 Reset mid-stream: rst=1 with two beats in flight -> next cycle out_valid=0, and neither beat ever appears at the output.
REQ-028 Parameter sweep: WIDTH in {8, 16, 64} and STAGES in {1, max}, with 10k random beats and random out_ready, checked against a reference model for sum_dif, C, V, N, Z and latency.

Source files
------------

// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cla_pkg
// Description : Shared constants, flag bundle and saturation helper for the
//               pipelined carry-lookahead adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package cla_pkg;

  // Width of one lookahead group
  localparam int GROUP_W = 4;

  // Widest datapath the saturation helper can build a value for
  localparam int SAT_MAX_W = 256;

  // Arithmetic status flags reported alongside every result
  typedef struct packed {
    logic C;
    logic V;
    logic N;
    logic Z;
  } flags_t;

  // Clamp value for a signed overflow: 0111..1 when the overflow went
  // positive (neg=0), 1000..0 when it went negative (neg=1). Callers
  // size-cast the result down to their own width.
  function automatic logic [SAT_MAX_W-1:0] sat_value(input int unsigned width,
                                                     input logic        neg);
    logic [SAT_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < SAT_MAX_W; i++) begin
      if (i + 1 < width) begin
        r[i] = ~neg;
      end else if (i + 1 == width) begin
        r[i] = neg;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cla_group4.sv
`default_nettype none
// ============================================================================
// Module      : cla_group4
// Description : Combinational 4-bit carry-lookahead group. Produces the
//               group sum plus group propagate/generate for the next level.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_group4
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               add_sub,
  input  logic               cin,
  output logic [GROUP_W-1:0] sum,
  output logic               P,
  output logic               G
);

  logic [GROUP_W-1:0] w_bx;
  logic [GROUP_W-1:0] w_p;
  logic [GROUP_W-1:0] w_g;
  logic [GROUP_W-1:0] w_c;

  // b is inverted for subtract; the +1 comes from the caller's carry-in
  assign w_bx = b ^ {GROUP_W{add_sub}};
  assign w_p  = a ^ w_bx;
  assign w_g  = a & w_bx;

  // Bit-level lookahead carries inside the group
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);

  assign sum = w_p ^ w_c;

  // Group terms are independent of cin so the upper level can look ahead
  assign P = &w_p;
  assign G = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule
`default_nettype wire

// File: rtl/cla_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cla_addsub_pipe
// Description : Pipelined two-level carry-lookahead adder/subtractor with
//               optional signed saturation and C/V/N/Z flags. Each stage
//               resolves one segment of 4-bit groups, LSB segment first, and
//               passes its carry to the next stage through a register.
//               A single global enable stalls every stage together.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,  // multiple of 4, at least 8
  parameter int STAGES = 2    // 1..WIDTH/4, must divide WIDTH/4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             add_sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_dif,
  output logic             C,
  output logic             V,
  output logic             N,
  output logic             Z
);

  localparam int NGROUPS = WIDTH / GROUP_W;
  localparam int GPS     = NGROUPS / STAGES;  // groups per stage
  localparam int SEG_W   = GPS * GROUP_W;     // bits per stage

  // Stage-input view: index 0 is the ports, index k>0 is the register
  // rank written by stage k-1.
  logic              w_en;
  logic [WIDTH-1:0]  w_a   [STAGES];
  logic [WIDTH-1:0]  w_b   [STAGES];
  logic [WIDTH-1:0]  w_sum [STAGES];
  logic [STAGES-1:0] w_cin;
  logic [STAGES-1:0] w_as;
  logic [STAGES-1:0] w_sat;
  logic [STAGES-1:0] w_vld;

  logic              out_valid_q;
  logic [WIDTH-1:0]  sum_dif_q;
  flags_t            flags_q;

  // Whole pipe moves only when the output slot is free or being drained
  assign w_en     = ~out_valid_q | out_ready;
  assign in_ready = w_en;

  assign w_a[0]   = a;
  assign w_b[0]   = b;
  assign w_sum[0] = '0;
  assign w_cin[0] = carry_in;
  assign w_as[0]  = add_sub;
  assign w_sat[0] = sat;
  assign w_vld[0] = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG_W;

    logic [SEG_W-1:0] w_seg_sum;
    logic [GPS-1:0]   w_gp;
    logic [GPS-1:0]   w_gg;
    logic [GPS:0]     w_gc;
    logic [WIDTH-1:0] w_sum_nxt;

    for (genvar j = 0; j < GPS; j++) begin : g_grp
      cla_group4 u_grp (
        .a       (w_a[k][LO + j*GROUP_W +: GROUP_W]),
        .b       (w_b[k][LO + j*GROUP_W +: GROUP_W]),
        .add_sub (w_as[k]),
        .cin     (w_gc[j]),
        .sum     (w_seg_sum[j*GROUP_W +: GROUP_W]),
        .P       (w_gp[j]),
        .G       (w_gg[j])
      );
    end

    // Second-level lookahead: each group carry as a flat sum of products
    always_comb begin
      logic prod;
      prod    = 1'b0;
      w_gc    = '0;
      w_gc[0] = w_cin[k];
      for (int j = 0; j < GPS; j++) begin
        prod = w_cin[k];
        for (int i = 0; i <= j; i++) begin
          prod = prod & w_gp[i];
        end
        w_gc[j+1] = prod;
        for (int i = 0; i <= j; i++) begin
          prod = w_gg[i];
          for (int m = i + 1; m <= j; m++) begin
            prod = prod & w_gp[m];
          end
          w_gc[j+1] = w_gc[j+1] | prod;
        end
      end
    end

    // Merge this segment's sum bits into the partial result
    always_comb begin
      w_sum_nxt             = w_sum[k];
      w_sum_nxt[LO +: SEG_W] = w_seg_sum;
    end

    if (k < STAGES - 1) begin : g_mid
      logic             vld_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] sum_q;
      logic             cout_q;
      logic             as_q;
      logic             sat_q;

      // Stage occupancy: flushed by reset, advances with the global enable
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= 1'b0;
        end else if (w_en) begin
          vld_q <= w_vld[k];
        end
      end

      // Beat payload travels with its valid bit; no reset needed
      always_ff @(posedge clk) begin
        if (w_en) begin
          a_q    <= w_a[k];
          b_q    <= w_b[k];
          sum_q  <= w_sum_nxt;
          cout_q <= w_gc[GPS];
          as_q   <= w_as[k];
          sat_q  <= w_sat[k];
        end
      end

      assign w_a[k+1]   = a_q;
      assign w_b[k+1]   = b_q;
      assign w_sum[k+1] = sum_q;
      assign w_cin[k+1] = cout_q;
      assign w_as[k+1]  = as_q;
      assign w_sat[k+1] = sat_q;
      assign w_vld[k+1] = vld_q;
    end else begin : g_last
      logic             w_cin_msb;
      logic             w_v_raw;
      logic [WIDTH-1:0] w_res_d;
      flags_t           w_flags_d;

      // Overflow from the MSB carries, then optional clamp and flags
      always_comb begin
        w_cin_msb = w_sum_nxt[WIDTH-1] ^ w_a[k][WIDTH-1]
                  ^ w_b[k][WIDTH-1] ^ w_as[k];
        w_v_raw   = w_cin_msb ^ w_gc[GPS];
        w_res_d   = w_sum_nxt;
        if (w_sat[k] && w_v_raw) begin
          w_res_d = WIDTH'(sat_value(WIDTH, w_a[k][WIDTH-1]));
        end
        w_flags_d   = '0;
        w_flags_d.C = w_gc[GPS];
        w_flags_d.V = w_v_raw;
        w_flags_d.N = w_res_d[WIDTH-1];
        w_flags_d.Z = (w_res_d == '0);
      end

      // Output register: holds while the consumer is not ready
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid_q <= 1'b0;
          sum_dif_q   <= '0;
          flags_q     <= '0;
        end else if (w_en) begin
          out_valid_q <= w_vld[k];
          sum_dif_q   <= w_res_d;
          flags_q     <= w_flags_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum_dif   = sum_dif_q;
  assign C         = flags_q.C;
  assign V         = flags_q.V;
  assign N         = flags_q.N;
  assign Z         = flags_q.Z;

endmodule
`default_nettype wire

// File: tb/tb_cla_addsub_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cla_addsub_pipe
// Description : Scoreboard bench for cla_addsub_pipe: directed corner cases,
//               stall, mid-stream reset and random traffic vs. a plain
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_addsub_pipe;

  parameter int WIDTH  = 32;
  parameter int STAGES = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             add_sub;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_dif;
  logic             C;
  logic             V;
  logic             N;
  logic             Z;

  always #5 clk = ~clk;

  cla_addsub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .add_sub   (add_sub),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_dif   (sum_dif),
    .C         (C),
    .V         (V),
    .N         (N),
    .Z         (Z)
  );

  typedef struct {
    logic [WIDTH-1:0] s;
    logic [3:0]       f;  // {C,V,N,Z}
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void checkw(input string name, input logic [WIDTH-1:0] act,
                                 input logic [WIDTH-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endfunction

  function automatic void check1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, req);
    end
  endfunction

  // Reference: plain wide addition, overflow from operand/result signs
  function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic mcin, input logic mas, input logic msat);
    exp_t             e;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] raw;
    logic             cf;
    logic             vf;
    bx   = mas ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bx} + {{WIDTH{1'b0}}, mcin};
    raw  = full[WIDTH-1:0];
    cf   = full[WIDTH];
    vf   = (ma[WIDTH-1] == bx[WIDTH-1]) && (raw[WIDTH-1] != ma[WIDTH-1]);
    if (msat && vf) begin
      e.s = ma[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      e.s = raw;
    end
    e.f = {cf, vf, e.s[WIDTH-1], (e.s == '0)};
    return e;
  endfunction

  function automatic logic [WIDTH-1:0] rand_word();
    logic [WIDTH-1:0] w;
    w = '0;
    case ($urandom_range(0, 9))
      0: w = '0;
      1: w = '1;
      2: w = {1'b0, {(WIDTH-1){1'b1}}};
      3: w = {1'b1, {(WIDTH-1){1'b0}}};
      default: begin
        for (int i = 0; i < WIDTH; i += 32) begin
          w = (w << 32) | WIDTH'($urandom);
        end
      end
    endcase
    return w;
  endfunction

  // Monitor: pops the scoreboard on every handshake, checks held outputs
  exp_t             mon_e;
  logic             held_v = 1'b0;
  logic [WIDTH-1:0] held_s;
  logic [3:0]       held_f;

  always @(negedge clk) begin
    if (rst) begin
      held_v <= 1'b0;
    end else begin
      check1("in_ready_rule", in_ready, !out_valid || out_ready);
      if (held_v) begin
        check1("hold_valid", out_valid, 1'b1);
        checkw("hold_sum", sum_dif, held_s);
        checkw("hold_flags", WIDTH'({C, V, N, Z}), WIDTH'(held_f));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got sum %h want no beat", sum_dif);
        end else begin
          mon_e = exp_q.pop_front();
          checkw("sum_dif", sum_dif, mon_e.s);
          checkw("flags_CVNZ", WIDTH'({C, V, N, Z}), WIDTH'(mon_e.f));
        end
        held_v <= 1'b0;
      end else if (out_valid) begin
        held_v <= 1'b1;
        held_s <= sum_dif;
        held_f <= {C, V, N, Z};
      end else begin
        held_v <= 1'b0;
      end
    end
  end

  // One clock of stimulus; entered and left at posedge+1
  task automatic drive_cycle(input logic v, input logic [WIDTH-1:0] ta,
                             input logic [WIDTH-1:0] tb, input logic tci,
                             input logic tas, input logic tsat, input logic ordy,
                             output logic acc);
    in_valid  = v;
    a         = ta;
    b         = tb;
    carry_in  = tci;
    add_sub   = tas;
    sat       = tsat;
    out_ready = ordy;
    @(negedge clk);
    acc = v && in_ready;
    #1;
    if (acc) exp_q.push_back(model(ta, tb, tci, tas, tsat));
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                           input logic tci, input logic tas, input logic tsat,
                           input int ready_pct);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 100) begin
      drive_cycle(1'b1, ta, tb, tci, tas, tsat,
                  ($urandom_range(0, 99) < ready_pct), acc);
      tries++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept want accept within 100 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkw("drain_left", WIDTH'(exp_q.size()), '0);
    @(posedge clk);
    #1;
    check1("idle_out_valid", out_valid, 1'b0);
  endtask

  // Single beat into an idle pipe with out_ready=1; measures cycles to out_valid
  task automatic latency_beat(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                              input logic tci, input logic tas, input logic tsat);
    logic acc;
    int   n;
    drive_cycle(1'b1, ta, tb, tci, tas, tsat, 1'b1, acc);
    check1("lat_accept", acc, 1'b1);
    in_valid = 1'b0;
    n = 1;
    while (n <= STAGES + 8) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      #1;
      n++;
    end
    checkw("latency", WIDTH'(n), WIDTH'(STAGES));
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] st_a [4];
  logic [WIDTH-1:0] st_b [4];

  initial begin
    logic acc;
    int   idx;
    int   guard;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    carry_in  = 1'b0;
    add_sub   = 1'b0;
    sat       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_out_valid", out_valid, 1'b0);
    checkw("rst_sum", sum_dif, '0);
    checkw("rst_flags", WIDTH'({C, V, N, Z}), '0);
    check1("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Corner cases: positive overflow raw and saturated, zero results
    latency_beat({1'b0, {(WIDTH-1){1'b1}}}, WIDTH'(1), 1'b0, 1'b0, 1'b0);
    latency_beat({1'b0, {(WIDTH-1){1'b1}}}, WIDTH'(1), 1'b0, 1'b0, 1'b1);
    latency_beat(WIDTH'(5), WIDTH'(5), 1'b1, 1'b1, 1'b0);
    latency_beat('1, WIDTH'(1), 1'b0, 1'b0, 1'b0);
    latency_beat({1'b1, {(WIDTH-1){1'b0}}}, WIDTH'(1), 1'b1, 1'b1, 1'b1);
    latency_beat(WIDTH'(3), WIDTH'(7), 1'b1, 1'b1, 1'b0);
    drain();

    // Back-to-back beats against a stalled consumer
    for (int i = 0; i < 4; i++) begin
      st_a[i] = rand_word();
      st_b[i] = rand_word();
    end
    idx = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      drive_cycle(1'b1, st_a[idx], st_b[idx], st_a[idx][0], st_b[idx][0],
                  st_a[idx][1], 1'b0, acc);
      if (acc) idx++;
    end
    check1("stall_out_valid", out_valid, 1'b1);
    check1("stall_in_ready", in_ready, 1'b0);
    guard = 0;
    while (idx < 4 && guard < 50) begin
      drive_cycle(1'b1, st_a[idx], st_b[idx], st_a[idx][0], st_b[idx][0],
                  st_a[idx][1], 1'b1, acc);
      if (acc) idx++;
      guard++;
    end
    checkw("stall_all_sent", WIDTH'(idx), WIDTH'(4));
    drain();

    // Reset with beats in flight: they must vanish
    drive_cycle(1'b1, rand_word(), rand_word(), 1'b0, 1'b0, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, rand_word(), rand_word(), 1'b1, 1'b1, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    rst      = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check1("midrst_out_valid", out_valid, 1'b0);
    checkw("midrst_sum", sum_dif, '0);
    checkw("midrst_flags", WIDTH'({C, V, N, Z}), '0);
    check1("midrst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_beat(rand_word(), rand_word(), 1'(($urandom) & 1), 1'(($urandom) & 1),
                1'(($urandom) & 1), 100);
    end
    drain();

    // Random traffic with bubbles and random backpressure
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        drive_cycle(1'b0, rand_word(), rand_word(), 1'b0, 1'b0, 1'b0,
                    1'(($urandom) & 1), acc);
      end
      send_beat(rand_word(), rand_word(), 1'(($urandom) & 1), 1'(($urandom) & 1),
                1'(($urandom) & 1), 70);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
